// File: rtl/change_dispenser_pkg.sv
// rtl/change_dispenser_pkg.sv - shared states, hopper codes, denominations and defaults
package change_dispenser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_REQ,
    ST_RELEASE,
    ST_DONE
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_1    = 2'b01;
  localparam logic [1:0] SEL_2    = 2'b10;
  localparam logic [1:0] SEL_5    = 2'b11;

  localparam logic [7:0] DENOM_1 = 8'd1;
  localparam logic [7:0] DENOM_2 = 8'd2;
  localparam logic [7:0] DENOM_5 = 8'd5;

  localparam int TUBE_CAP_DEFAULT    = 15;
  localparam int ACK_TIMEOUT_DEFAULT = 255;

  function automatic logic [7:0] sel_value(input logic [1:0] sel);
    case (sel)
      SEL_1:   sel_value = DENOM_1;
      SEL_2:   sel_value = DENOM_2;
      SEL_5:   sel_value = DENOM_5;
      default: sel_value = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_coin_tube.sv
// rtl/change_dispenser_coin_tube.sv - saturating 4-bit coin count with inc, dec and load-to-cap
module coin_tube #(
  parameter int CAP = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  output logic [3:0] cnt
);

  localparam logic [3:0] CAP_L = 4'(CAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= CAP_L;
    end else if (inc && !dec) begin
      if (cnt < CAP_L) cnt <= cnt + 4'd1;
    end else if (dec && !inc) begin
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - pays out change from three coin tubes over a four-phase hopper handshake
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int TUBE_CAP    = TUBE_CAP_DEFAULT,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] change_amount,
  input  logic       coin_accepted,
  input  logic [7:0] coin_value,
  input  logic       refill,
  output logic       hopper_req,
  output logic [1:0] hopper_sel,
  input  logic       hopper_ack,
  output logic       busy,
  output logic       done,
  output logic [7:0] shortfall,
  output logic       fault,
  output logic [3:0] tube1_cnt,
  output logic [3:0] tube2_cnt,
  output logic [3:0] tube5_cnt
);

  localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state;
  logic [7:0] remaining;
  logic [7:0] wait_cnt;
  logic [1:0] pick_sel;
  logic       release_done;
  logic       wait_hit;

  // Largest denomination that still fits and has stock; never exceeds remaining.
  always_comb begin
    pick_sel = SEL_NONE;
    if (remaining >= DENOM_5 && tube5_cnt != 4'd0)      pick_sel = SEL_5;
    else if (remaining >= DENOM_2 && tube2_cnt != 4'd0) pick_sel = SEL_2;
    else if (remaining >= DENOM_1 && tube1_cnt != 4'd0) pick_sel = SEL_1;
  end

  assign release_done = (state == ST_RELEASE) && !hopper_ack;
  assign wait_hit     = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      remaining  <= 8'd0;
      wait_cnt   <= 8'd0;
      hopper_req <= 1'b0;
      hopper_sel <= SEL_NONE;
      busy       <= 1'b0;
      done       <= 1'b0;
      shortfall  <= 8'd0;
      fault      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            remaining <= change_amount;
            fault     <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (pick_sel != SEL_NONE) begin
            hopper_sel <= pick_sel;
            hopper_req <= 1'b1;
            wait_cnt   <= 8'd0;
            state      <= ST_REQ;
          end else begin
            done      <= 1'b1;
            shortfall <= remaining;
            state     <= ST_DONE;
          end
        end
        ST_REQ: begin
          if (hopper_ack) begin
            hopper_req <= 1'b0;
            wait_cnt   <= 8'd0;
            state      <= ST_RELEASE;
          end else if (wait_hit) begin
            hopper_req <= 1'b0;
            hopper_sel <= SEL_NONE;
            fault      <= 1'b1;
            done       <= 1'b1;
            shortfall  <= remaining;
            state      <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_RELEASE: begin
          if (!hopper_ack) begin
            remaining  <= remaining - sel_value(hopper_sel);
            hopper_sel <= SEL_NONE;
            state      <= ST_SELECT;
          end else if (wait_hit) begin
            hopper_sel <= SEL_NONE;
            fault      <= 1'b1;
            done       <= 1'b1;
            shortfall  <= remaining;
            state      <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Inserts and deductions land in the same edge; the tube nets them, refill overrides.
  coin_tube #(.CAP(TUBE_CAP)) u_tube1 (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (coin_accepted && coin_value == DENOM_1),
    .dec  (release_done && hopper_sel == SEL_1),
    .load (refill),
    .cnt  (tube1_cnt)
  );

  coin_tube #(.CAP(TUBE_CAP)) u_tube2 (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (coin_accepted && coin_value == DENOM_2),
    .dec  (release_done && hopper_sel == SEL_2),
    .load (refill),
    .cnt  (tube2_cnt)
  );

  coin_tube #(.CAP(TUBE_CAP)) u_tube5 (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (coin_accepted && coin_value == DENOM_5),
    .dec  (release_done && hopper_sel == SEL_5),
    .load (refill),
    .cnt  (tube5_cnt)
  );

endmodule
